// File: rtl/conv_pkg.sv
// Shared types and helpers for the conv-top buffer write paths.
package conv_pkg;

   localparam int DATA_WIDTH_DEF = 16;
   localparam int LANES_DEF      = 4;

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      FULL
   } packer_state_t;

   // Zero or out-of-range lane counts mean "use every lane".
   function automatic int unsigned clamp_lanes(input int unsigned raw, input int unsigned max_lanes);
      return (raw == 0 || raw > max_lanes) ? max_lanes : raw;
   endfunction

endpackage

// File: rtl/bank_write_packer.sv
// Packs a one-element-per-beat stream into LANES-wide double_buffer words and
// swaps banks once a configured fill is written and the reader has released its bank.
//
// state | meaning
// IDLE  | waiting for a config handshake
// FILL  | accepting beats, writing one buffer word per lanes beats
// FULL  | bank written; waiting for the read bank before switch_banks
module bank_write_packer
   import conv_pkg::*;
#(
   parameter int DATA_WIDTH      = DATA_WIDTH_DEF,
   parameter int LANES           = LANES_DEF,
   parameter int BANK_ADDR_WIDTH = 8,
   parameter int CONFIG_WIDTH    = 32
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          soft_clr,
   input  logic                          cfg_vld,
   output logic                          cfg_rdy,
   input  logic [CONFIG_WIDTH-1:0]       cfg_words,
   input  logic [$clog2(LANES):0]        cfg_lanes,
   input  logic [DATA_WIDTH-1:0]         in_dat,
   input  logic                          in_vld,
   output logic                          in_rdy,
   input  logic                          rd_done,
   output logic                          wen,
   output logic [BANK_ADDR_WIDTH-1:0]    wadr,
   output logic [DATA_WIDTH*LANES-1:0]   wdata,
   output logic                          switch_banks,
   output logic [15:0]                   fills_done
);

   localparam int LCW = (LANES > 1) ? $clog2(LANES) : 1;
   localparam logic [CONFIG_WIDTH:0] DEPTH = (CONFIG_WIDTH+1)'(2**BANK_ADDR_WIDTH);

   packer_state_t                        state_q, state_d;
   logic [LCW-1:0]                       lanes_m1_q, lanes_m1_d;
   logic [BANK_ADDR_WIDTH-1:0]           words_m1_q, words_m1_d;
   logic [LCW-1:0]                       lane_cnt_q, lane_cnt_d;
   logic [BANK_ADDR_WIDTH-1:0]           word_cnt_q, word_cnt_d;
   logic [LANES-1:0][DATA_WIDTH-1:0]     pack_q, pack_d;
   logic [LANES-1:0][DATA_WIDTH-1:0]     word_v;
   logic                                 wen_q, wen_d;
   logic [BANK_ADDR_WIDTH-1:0]           wadr_q, wadr_d;
   logic [DATA_WIDTH*LANES-1:0]          wdata_q, wdata_d;
   logic                                 switch_q, switch_d;
   logic                                 read_busy_q, read_busy_d;
   logic [15:0]                          fills_q, fills_d;
   logic [LCW-1:0]                       cfg_lanes_m1;
   logic [BANK_ADDR_WIDTH-1:0]           cfg_words_m1;

   assign cfg_lanes_m1 = LCW'(clamp_lanes(32'(cfg_lanes), LANES) - 32'd1);
   assign cfg_words_m1 = (cfg_words == '0 || {1'b0, cfg_words} > DEPTH)
                         ? '1 : BANK_ADDR_WIDTH'(cfg_words - CONFIG_WIDTH'(1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         lanes_m1_q  <= '0;
         words_m1_q  <= '0;
         lane_cnt_q  <= '0;
         word_cnt_q  <= '0;
         pack_q      <= '0;
         wen_q       <= 1'b0;
         wadr_q      <= '0;
         wdata_q     <= '0;
         switch_q    <= 1'b0;
         read_busy_q <= 1'b0;
         fills_q     <= '0;
      end else begin
         state_q     <= state_d;
         lanes_m1_q  <= lanes_m1_d;
         words_m1_q  <= words_m1_d;
         lane_cnt_q  <= lane_cnt_d;
         word_cnt_q  <= word_cnt_d;
         pack_q      <= pack_d;
         wen_q       <= wen_d;
         wadr_q      <= wadr_d;
         wdata_q     <= wdata_d;
         switch_q    <= switch_d;
         read_busy_q <= read_busy_d;
         fills_q     <= fills_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      lanes_m1_d  = lanes_m1_q;
      words_m1_d  = words_m1_q;
      lane_cnt_d  = lane_cnt_q;
      word_cnt_d  = word_cnt_q;
      pack_d      = pack_q;
      word_v      = '0;
      wen_d       = 1'b0;
      wadr_d      = wadr_q;
      wdata_d     = wdata_q;
      switch_d    = 1'b0;
      read_busy_d = read_busy_q;
      fills_d     = fills_q;

      if (rd_done) read_busy_d = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (cfg_vld) begin
               lanes_m1_d = cfg_lanes_m1;
               words_m1_d = cfg_words_m1;
               lane_cnt_d = '0;
               word_cnt_d = '0;
               state_d    = FILL;
            end
         end
         FILL: begin
            if (in_vld) begin
               pack_d[lane_cnt_q] = in_dat;
               if (lane_cnt_q == lanes_m1_q) begin
                  // Lanes from earlier, wider words may still hold data; mask them.
                  for (int i = 0; i < LANES; i++)
                     word_v[i] = (LCW'(i) <= lanes_m1_q) ? pack_d[i] : '0;
                  wen_d      = 1'b1;
                  wadr_d     = word_cnt_q;
                  wdata_d    = word_v;
                  lane_cnt_d = '0;
                  word_cnt_d = word_cnt_q + 1'b1;
                  if (word_cnt_q == words_m1_q) state_d = FULL;
               end else begin
                  lane_cnt_d = lane_cnt_q + 1'b1;
               end
            end
         end
         FULL: begin
            // A rd_done coinciding with the swap releases the old bank and is consumed by it.
            if (!read_busy_q || rd_done) begin
               switch_d    = 1'b1;
               read_busy_d = 1'b1;
               word_cnt_d  = '0;
               fills_d     = fills_q + 16'd1;
               state_d     = FILL;
            end
         end
         default: state_d = IDLE;
      endcase

      if (soft_clr) begin
         state_d     = IDLE;
         lane_cnt_d  = '0;
         word_cnt_d  = '0;
         read_busy_d = 1'b0;
         wen_d       = 1'b0;
         switch_d    = 1'b0;
      end
   end

   assign cfg_rdy      = (state_q == IDLE);
   assign in_rdy       = (state_q == FILL);
   assign wen          = wen_q;
   assign wadr         = wadr_q;
   assign wdata        = wdata_q;
   assign switch_banks = switch_q;
   assign fills_done   = fills_q;

endmodule

// File: tb/tb_bank_write_packer.sv
// Scoreboard bench for bank_write_packer: a word-level model queues expected
// writes and bank swaps; a negedge monitor pops and compares them.
module tb_bank_write_packer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        soft_clr = 1'b0;
   logic        cfg_vld = 1'b0;
   logic        cfg_rdy;
   logic [31:0] cfg_words = '0;
   logic [2:0]  cfg_lanes = '0;
   logic [15:0] in_dat = '0;
   logic        in_vld = 1'b0;
   logic        in_rdy;
   logic        rd_done = 1'b0;
   logic        wen;
   logic [7:0]  wadr;
   logic [63:0] wdata;
   logic        switch_banks;
   logic [15:0] fills_done;

   bank_write_packer dut (
      .clk(clk), .rst(rst), .soft_clr(soft_clr), .cfg_vld(cfg_vld), .cfg_rdy(cfg_rdy),
      .cfg_words(cfg_words), .cfg_lanes(cfg_lanes), .in_dat(in_dat), .in_vld(in_vld),
      .in_rdy(in_rdy), .rd_done(rd_done), .wen(wen), .wadr(wadr), .wdata(wdata),
      .switch_banks(switch_banks), .fills_done(fills_done)
   );

   initial forever #5 clk = ~clk;

   typedef struct {
      bit          sw;
      logic [7:0]  adr;
      logic [63:0] data;
      logic [15:0] fills;
   } ev_t;

   ev_t         exp_q[$];
   logic [15:0] m_parts[$];
   int          m_lanes, m_words, m_word_idx, m_fills;
   int          n_checks = 0, n_fail = 0;
   int          cyc = 0, wen_count = 0, sw_count = 0, last_wen_cyc = 0, sw_cyc = 0;
   int          wen_cycs[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Word-level reference: groups accepted beats into words, words into fills.
   function automatic void model_accept(input logic [15:0] d);
      ev_t e;
      m_parts.push_back(d);
      if (m_parts.size() == m_lanes) begin
         e.sw = 1'b0; e.adr = 8'(m_word_idx); e.data = '0; e.fills = '0;
         foreach (m_parts[i]) e.data[i*16 +: 16] = m_parts[i];
         exp_q.push_back(e);
         m_parts.delete();
         m_word_idx++;
         if (m_word_idx == m_words) begin
            m_fills++;
            e.sw = 1'b1; e.adr = '0; e.data = '0; e.fills = 16'(m_fills);
            exp_q.push_back(e);
            m_word_idx = 0;
         end
      end
   endfunction

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial forever begin
      ev_t e;
      @(negedge clk);
      if (!rst) begin
         if (wen) begin
            wen_count++; last_wen_cyc = cyc; wen_cycs.push_back(cyc);
            check("wen_expected", 64'(exp_q.size() > 0), 64'(1));
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("wen_kind", 64'(e.sw), 64'(0));
               check("wadr", 64'(wadr), 64'(e.adr));
               check("wdata", wdata, e.data);
            end
         end
         if (switch_banks) begin
            sw_count++; sw_cyc = cyc;
            check("switch_expected", 64'(exp_q.size() > 0), 64'(1));
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("switch_kind", 64'(e.sw), 64'(1));
               check("fills_done", 64'(fills_done), 64'(e.fills));
            end
         end
      end
   end

   task automatic configure(input int unsigned words, input int unsigned lanes);
      cfg_words = words; cfg_lanes = 3'(lanes); cfg_vld = 1'b1;
      @(posedge clk); #1;
      cfg_vld = 1'b0;
      m_lanes = (lanes == 0 || lanes > 4) ? 4 : int'(lanes);
      m_words = (words == 0 || words > 256) ? 256 : int'(words);
      m_word_idx = 0;
      m_parts.delete();
      check("cfg_to_fill_in_rdy", 64'(in_rdy), 64'(1));
   endtask

   task automatic do_soft_clr();
      soft_clr = 1'b1;
      @(posedge clk); #1;
      soft_clr = 1'b0;
      m_parts.delete();
      m_word_idx = 0;
      check("soft_clr_cfg_rdy", 64'(cfg_rdy), 64'(1));
   endtask

   // mode 0: back-to-back, 1: valid toggles every cycle, 2: random gaps. base 0 = random data.
   task automatic send_beats(input int n, input int mode, input int base);
      int sent = 0, budget = n * 8 + 200, phase = 0;
      logic [15:0] d;
      logic acc;
      while (sent < n && budget > 0) begin
         d = (base != 0) ? 16'(base + sent) : 16'($urandom);
         in_dat = d;
         in_vld = (mode == 0) ? 1'b1 : (mode == 1) ? (phase == 0) : ($urandom_range(0, 3) != 0);
         phase = 1 - phase;
         @(negedge clk);
         acc = in_vld && in_rdy;
         @(posedge clk); #1;
         if (acc) begin
            model_accept(d);
            sent++;
         end
         budget--;
      end
      in_vld = 1'b0;
      if (sent < n) check("beat_budget", 64'(sent), 64'(n));
   endtask

   task automatic wait_switch(input int target, input int budget);
      int n = 0;
      while (sw_count < target && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("switch_seen", 64'(sw_count >= target), 64'(1));
      @(posedge clk); #1;
   endtask

   task automatic pulse_rd_done();
      rd_done = 1'b1;
      @(posedge clk); #1;
      rd_done = 1'b0;
   endtask

   initial begin
      int wc0, sc0;
      m_fills = 0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_cfg_rdy", 64'(cfg_rdy), 64'(1));
      check("rst_in_rdy", 64'(in_rdy), 64'(0));
      check("rst_wen", 64'(wen), 64'(0));
      check("rst_switch", 64'(switch_banks), 64'(0));
      check("rst_fills", 64'(fills_done), 64'(0));
      check("rst_wadr_wdata", {wdata[55:0], wadr}, 64'(0));
      rst = 1'b0;
      @(posedge clk); #1;

      // Full-width words, stream 1..12.
      wc0 = wen_count;
      configure(3, 4);
      send_beats(12, 0, 1);
      wait_switch(1, 20);
      check("t1_wen_count", 64'(wen_count - wc0), 64'(3));
      check("t1_switch_after_wen", 64'(sw_cyc - last_wen_cyc), 64'(1));
      check("t1_fills", 64'(fills_done), 64'(1));

      // Three active lanes, then lanes=0 treated as four.
      do_soft_clr();
      configure(2, 3);
      send_beats(6, 0, 1);
      wait_switch(2, 20);
      do_soft_clr();
      configure(2, 0);
      send_beats(8, 0, 20);
      wait_switch(3, 20);

      // Reader still holds the bank: FULL is held until rd_done.
      sc0 = sw_count;
      send_beats(8, 0, 40);
      repeat (10) @(posedge clk);
      #1;
      check("t3_hold_no_switch", 64'(sw_count), 64'(sc0));
      check("t3_hold_in_rdy", 64'(in_rdy), 64'(0));
      pulse_rd_done();
      check("t3_switch_on_rd_done", 64'(switch_banks), 64'(1));
      check("t3_in_rdy_after", 64'(in_rdy), 64'(1));
      @(posedge clk); #1;

      // rd_done coinciding with a swap is consumed; the next fill waits.
      do_soft_clr();
      configure(2, 0);
      send_beats(8, 0, 60);
      pulse_rd_done();
      check("t4_switch", 64'(switch_banks), 64'(1));
      sc0 = sw_count + 1;
      send_beats(8, 2, 0);
      repeat (6) @(posedge clk);
      #1;
      check("t4_stall_no_switch", 64'(sw_count), 64'(sc0));
      check("t4_stall_in_rdy", 64'(in_rdy), 64'(0));
      pulse_rd_done();
      wait_switch(sc0 + 1, 10);

      // Valid toggling every cycle.
      do_soft_clr();
      configure(3, 4);
      wen_cycs.delete();
      send_beats(12, 1, 1);
      wait_switch(sw_count + 1, 20);
      check("t5_wen_n", 64'(wen_cycs.size()), 64'(3));
      if (wen_cycs.size() == 3) begin
         check("t5_spacing01", 64'(wen_cycs[1] - wen_cycs[0]), 64'(8));
         check("t5_spacing12", 64'(wen_cycs[2] - wen_cycs[1]), 64'(8));
      end

      // soft_clr mid-word, then rst mid-FILL.
      do_soft_clr();
      configure(3, 4);
      wc0 = wen_count;
      send_beats(2, 0, 100);
      do_soft_clr();
      configure(3, 4);
      send_beats(2, 0, 200);
      rst = 1'b1;
      m_parts.delete(); m_word_idx = 0; m_fills = 0;
      #1;
      check("t6_rst_cfg_rdy", 64'(cfg_rdy), 64'(1));
      check("t6_rst_fills", 64'(fills_done), 64'(0));
      check("t6_rst_wen", 64'(wen), 64'(0));
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      check("t6_no_wen", 64'(wen_count), 64'(wc0));
      sc0 = sw_count;
      configure(2, 2);
      send_beats(4, 0, 0);
      wait_switch(sc0 + 1, 20);

      // Randomised configs; first pass exercises the full 256-word bank.
      for (int it = 0; it < 6; it++) begin
         int unsigned w, l;
         do_soft_clr();
         w = (it == 0) ? 0 : (it == 1) ? 300 : $urandom_range(1, 6);
         l = $urandom_range(0, 7);
         if (it == 1) l = 1;
         configure(w, l);
         sc0 = sw_count;
         send_beats(m_lanes * m_words, (it < 2) ? 0 : 2, 0);
         wait_switch(sc0 + 1, 20);
         send_beats(m_lanes * m_words, 2, 0);
         repeat ($urandom_range(0, 4)) @(posedge clk);
         #1;
         pulse_rd_done();
         wait_switch(sc0 + 2, 20);
      end

      repeat (3) @(posedge clk);
      #1;
      check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
